// File: rtl/el2_pkg.sv
// Shared EL2 decode types and constants used by the GPR write-back arbiter.
package el2_pkg;

  localparam int unsigned EL2_GPR_WB_NREQ = 2;

  typedef struct packed {
    logic        vld;
    logic [4:0]  addr;
    logic [31:0] data;
  } el2_gpr_wb_req_t;

endpackage

// File: rtl/el2_dec_gpr_wb_sb.sv
// Pending-destination scoreboard with hazard lookup for two decode read ports.
// Optional same-cycle write forwarding under EL2_GPR_WB_FWD_EN.
module el2_dec_gpr_wb_sb
  import el2_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        set_vld,
  input  logic [4:0]  set_addr,
  input  logic        clr_vld,
  input  logic [4:0]  clr_addr,
  input  logic [4:0]  raddr0,
  input  logic [4:0]  raddr1,
  output logic        hazard0,
  output logic        hazard1,
  output logic [31:1] pend
`ifdef EL2_GPR_WB_FWD_EN
  ,
  input  logic [31:0] clr_data,
  output logic        fwd0_vld,
  output logic        fwd1_vld,
  output logic [31:0] fwd_data
`endif
);

  logic [31:1] pend_q;
  logic [31:0] pend_ext;

  // Set is checked first so a same-cycle set and clear leaves the bit pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
    end else begin
      for (int unsigned i = 1; i < 32; i++) begin
        if (set_vld && (set_addr == 5'(i)))
          pend_q[i] <= 1'b1;
        else if (clr_vld && (clr_addr == 5'(i)))
          pend_q[i] <= 1'b0;
      end
    end
  end

  assign pend_ext = {pend_q, 1'b0};
  assign pend     = pend_q;

`ifdef EL2_GPR_WB_FWD_EN
  logic hit0, hit1;
  assign hit0     = clr_vld && (clr_addr == raddr0);
  assign hit1     = clr_vld && (clr_addr == raddr1);
  assign hazard0  = pend_ext[raddr0] & ~hit0;
  assign hazard1  = pend_ext[raddr1] & ~hit1;
  assign fwd0_vld = hit0;
  assign fwd1_vld = hit1;
  assign fwd_data = clr_data;
`else
  assign hazard0 = pend_ext[raddr0];
  assign hazard1 = pend_ext[raddr1];
`endif

endmodule

// File: rtl/el2_dec_gpr_wb_arb.sv
// Write-back arbiter for GPR port 2: buffers load-return and divider results.
// Define EL2_GPR_WB_FWD_EN to add same-cycle forwarding outputs.
module el2_dec_gpr_wb_arb
  import el2_pkg::*;
#(
  parameter int unsigned STARVE_CYC = 8
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [EL2_GPR_WB_NREQ-1:0]              req_vld,
  input  logic [EL2_GPR_WB_NREQ-1:0][4:0]         req_addr,
  input  logic [EL2_GPR_WB_NREQ-1:0][31:0]        req_data,
  output logic [EL2_GPR_WB_NREQ-1:0]              req_rdy,
  input  logic                                    port_busy,
  output logic                                    wen,
  output logic [4:0]                              waddr,
  output logic [31:0]                             wd,
  input  logic                                    sb_set_vld,
  input  logic [4:0]                              sb_set_addr,
  input  logic [4:0]                              raddr0,
  input  logic [4:0]                              raddr1,
  output logic                                    hazard0,
  output logic                                    hazard1,
  output logic [30:0]                             sb_pend,
  output logic                                    wb_starve
`ifdef EL2_GPR_WB_FWD_EN
  ,
  output logic                                    fwd0_vld,
  output logic                                    fwd1_vld,
  output logic [31:0]                             fwd_data
`endif
);

  localparam logic [7:0] STARVE_MAX = 8'(STARVE_CYC);

  el2_gpr_wb_req_t             hold_q [EL2_GPR_WB_NREQ];
  logic [EL2_GPR_WB_NREQ-1:0]  elig;
  logic [EL2_GPR_WB_NREQ-1:0]  accept;
  logic                        any_elig;
  logic                        gnt_vld;
  logic                        gnt_idx;
  logic                        rr_q;
  logic [7:0]                  cnt_q, cnt_nxt;
  logic                        starve_q;

  always_comb begin
    for (int unsigned i = 0; i < EL2_GPR_WB_NREQ; i++) begin
      elig[i]    = hold_q[i].vld & (hold_q[i].addr != '0);
      req_rdy[i] = ~hold_q[i].vld & ~rst;
      accept[i]  = req_vld[i] & req_rdy[i];
    end
  end

  assign any_elig = |elig;
  assign gnt_vld  = any_elig & ~port_busy & ~rst;
  assign gnt_idx  = (&elig) ? rr_q : elig[1];

  assign wen   = gnt_vld;
  assign waddr = gnt_vld ? hold_q[gnt_idx].addr : '0;
  assign wd    = gnt_vld ? hold_q[gnt_idx].data : '0;

  // x0 results sit for one cycle and then drop without ever being eligible.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < EL2_GPR_WB_NREQ; i++)
        hold_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < EL2_GPR_WB_NREQ; i++) begin
        if (accept[i])
          hold_q[i] <= '{vld: 1'b1, addr: req_addr[i], data: req_data[i]};
        else if (hold_q[i].vld &&
                 ((hold_q[i].addr == '0) || (gnt_vld && (gnt_idx == 1'(i)))))
          hold_q[i].vld <= 1'b0;
      end
    end
  end

  // Pointer only moves on a contested grant, so the loser of a contest wins the next one.
  always_ff @(posedge clk) begin
    if (rst)
      rr_q <= 1'b0;
    else if (gnt_vld && (&elig))
      rr_q <= ~gnt_idx;
  end

  always_comb begin
    cnt_nxt = cnt_q;
    if (!any_elig || wen)
      cnt_nxt = '0;
    else if (port_busy && (cnt_q != STARVE_MAX))
      cnt_nxt = cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      starve_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_nxt;
      starve_q <= (cnt_nxt == STARVE_MAX);
    end
  end

  assign wb_starve = starve_q;

  el2_dec_gpr_wb_sb u_sb (
    .clk      (clk),
    .rst      (rst),
    .set_vld  (sb_set_vld),
    .set_addr (sb_set_addr),
    .clr_vld  (wen),
    .clr_addr (waddr),
    .raddr0   (raddr0),
    .raddr1   (raddr1),
    .hazard0  (hazard0),
    .hazard1  (hazard1),
    .pend     (sb_pend)
`ifdef EL2_GPR_WB_FWD_EN
    ,
    .clr_data (wd),
    .fwd0_vld (fwd0_vld),
    .fwd1_vld (fwd1_vld),
    .fwd_data (fwd_data)
`endif
  );

endmodule
